// File: rtl/instr_receiver.sv
// ----------------------------------------------------------------------------
// instr_receiver
//   Builds 32-bit instructions from the host byte stream, MSB first, and
//   queues the finished words in a small FIFO. control_unit reads them through
//   the instr_ready / instr_ack / instr_in handshake. If the gap between bytes
//   of one word gets too long, the partial word is thrown away. The block
//   counts words dropped because the FIFO was full and partial words lost to
//   timeout.
//
// Parameters
//   TIMEOUT_CYCLES  idle clk cycles allowed between bytes of one word
//   FIFO_AW         log2 of FIFO depth in words
//
// Ports
//   clk            system clock
//   reset          asynchronous, active-high reset
//   rx_valid       one-cycle strobe, rx_data holds a new byte (never refused)
//   rx_data        received byte
//   instr_ready    FIFO non-empty, instr_in holds the oldest word
//   instr_ack      one-cycle pop strobe from control_unit
//   instr_in       oldest queued instruction
//   overflow       sticky flag, a completed word was dropped (FIFO full)
//   drop_count     completed words dropped, saturates at 255
//   timeout_count  partial words discarded by timeout, saturates at 255
//   status_clear   one-cycle strobe, clears overflow and both counters
// ----------------------------------------------------------------------------
module instr_receiver #(
    parameter int TIMEOUT_CYCLES = 500000,
    parameter int FIFO_AW        = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        instr_ready,
    input  logic        instr_ack,
    output logic [31:0] instr_in,
    output logic        overflow,
    output logic [7:0]  drop_count,
    output logic [7:0]  timeout_count,
    input  logic        status_clear
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [TW-1:0]      TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]      TIMER_ONE  = TW'(1);
    localparam logic [FIFO_AW:0]   COUNT_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   COUNT_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]         byte_idx;
    logic [23:0]        partial;        // the first three bytes, oldest in [23:16]
    logic [TW-1:0]      timer;

    logic [31:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW:0]   count;

    // ------------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------------
    logic        word_done;
    logic        fifo_full;
    logic        pop;
    logic        drop;
    logic        push;
    logic        timeout_hit;
    logic [31:0] word;

    assign word_done   = rx_valid && (byte_idx == 2'd3);
    assign word        = {partial, rx_data};
    assign fifo_full   = (count == COUNT_FULL);
    // An ack is ignored when the FIFO is empty, even if a word is being pushed
    // in the same cycle.
    assign pop         = instr_ack && (count != '0);
    // A pop in the same cycle frees a slot, so a full FIFO can still take the
    // new word.
    assign drop        = word_done && fifo_full && !pop;
    assign push        = word_done && !drop;
    // A byte that arrives on the expiry cycle wins over the timeout.
    assign timeout_hit = !rx_valid && (byte_idx != 2'd0) && (timer == TIMER_LAST);

    // ------------------------------------------------------------------------
    // Byte assembly and inter-byte timer
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples pre-edge values, and the order of the always blocks does
    // not matter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_idx <= 2'd0;
            partial  <= '0;
            timer    <= '0;
        end else if (rx_valid) begin
            // Shift on every byte. At byte3 the shift is harmless, because
            // the next word's first three bytes overwrite it.
            partial  <= {partial[15:0], rx_data};
            byte_idx <= byte_idx + 2'd1;
            timer    <= '0;
        end else if (byte_idx != 2'd0) begin
            if (timer == TIMER_LAST) begin
                byte_idx <= 2'd0;
                timer    <= '0;
            end else begin
                timer <= timer + TIMER_ONE;
            end
        end else begin
            timer <= '0;
        end
    end

    // ------------------------------------------------------------------------
    // Instruction FIFO
    // ------------------------------------------------------------------------
    // NOTE: the storage array is reset on purpose. instr_in reads mem[rd_ptr]
    // directly, so clearing the few words here makes every output 0 after
    // reset with no extra output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= word;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // The head holds until the ack that pops it. The slot under rd_ptr is
    // never rewritten while it is the head: that only happens when the FIFO
    // is full, and then a write needs a same-cycle pop.
    assign instr_ready = (count != '0);
    assign instr_in    = mem[rd_ptr];

    // ------------------------------------------------------------------------
    // Status flags and saturating counters
    // ------------------------------------------------------------------------
    logic [7:0] drop_count_next;
    logic [7:0] timeout_count_next;
    logic       overflow_next;

    // NOTE: each combinational output is first given a default at the top of
    // the block. No path through the block can then leave it unassigned, so
    // no latch is inferred.
    always_comb begin
        drop_count_next    = drop_count;
        timeout_count_next = timeout_count;
        overflow_next      = overflow;
        if (status_clear) begin
            // A clear still records an event that happens in the same cycle.
            drop_count_next    = {7'd0, drop};
            timeout_count_next = {7'd0, timeout_hit};
            overflow_next      = drop;
        end else begin
            if (drop && (drop_count != 8'hFF)) begin
                drop_count_next = drop_count + 8'd1;
            end
            if (timeout_hit && (timeout_count != 8'hFF)) begin
                timeout_count_next = timeout_count + 8'd1;
            end
            overflow_next = overflow | drop;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count    <= '0;
            timeout_count <= '0;
            overflow      <= 1'b0;
        end else begin
            drop_count    <= drop_count_next;
            timeout_count <= timeout_count_next;
            overflow      <= overflow_next;
        end
    end

endmodule
